// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 scan-code decoder: collapses E0/F0 prefix sequences into single key events with live modifier state.
// Optional Pause-key absorption is enabled by defining PS2_DECODER_PAUSE_EN.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_code,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [3:0] evt_mods,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;
  localparam logic [7:0] CODE_LSHF  = 8'h12;
  localparam logic [7:0] CODE_RSHF  = 8'h59;
  localparam logic [7:0] CODE_CTRL  = 8'h14;
  localparam logic [7:0] CODE_ALT   = 8'h11;
  localparam logic [7:0] CODE_CAPS  = 8'h58;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } state_t;

  typedef struct packed {
    logic caps_held;
    logic caps;
    logic ralt;
    logic lalt;
    logic rctrl;
    logic lctrl;
    logic rshift;
    logic lshift;
  } mod_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_next;
  mod_t             mods, mods_next;

  logic             fire;
  logic [7:0]       fire_code;
  logic             fire_ext;
  logic             fire_brk;
  logic             fire_mod_en;
  logic             load;
  logic             drop;
  logic [3:0]       mods_view;

`ifdef PS2_DECODER_PAUSE_EN
  logic [2:0]       pause_cnt, pause_cnt_next;
`endif

  // Host responses and keyboard status bytes that never start a key event.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) || (code == 8'hFA) ||
           (code == 8'hFC) || (code == 8'hFE) || (code == 8'hFF);
  endfunction

  always_comb begin
    state_next  = state;
    fire        = 1'b0;
    fire_code   = in_code;
    fire_ext    = 1'b0;
    fire_brk    = 1'b0;
    fire_mod_en = 1'b1;
`ifdef PS2_DECODER_PAUSE_EN
    pause_cnt_next = pause_cnt;
`endif
    if (in_valid) begin
      unique case (state)
        IDLE: begin
          if (in_code == CODE_EXT) begin
            state_next = EXT;
          end else if (in_code == CODE_BRK) begin
            state_next = BRK;
`ifdef PS2_DECODER_PAUSE_EN
          end else if (in_code == CODE_PAUSE) begin
            state_next     = PAUSE;
            pause_cnt_next = '0;
`endif
          end else if (!is_ignored(in_code)) begin
            fire = 1'b1;
          end
        end
        EXT: begin
          if (in_code == CODE_BRK) begin
            state_next = EXT_BRK;
          end else if (in_code != CODE_EXT) begin
            fire       = 1'b1;
            fire_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          fire       = 1'b1;
          fire_brk   = 1'b1;
          state_next = IDLE;
        end
        EXT_BRK: begin
          fire       = 1'b1;
          fire_ext   = 1'b1;
          fire_brk   = 1'b1;
          state_next = IDLE;
        end
        PAUSE: begin
`ifdef PS2_DECODER_PAUSE_EN
          // The Pause sequence is E1 plus seven payload bytes; report it once as code E1.
          if (pause_cnt == 3'd6) begin
            fire        = 1'b1;
            fire_code   = CODE_PAUSE;
            fire_mod_en = 1'b0;
            state_next  = IDLE;
          end else begin
            pause_cnt_next = pause_cnt + 3'd1;
          end
`else
          state_next = IDLE;
`endif
        end
        default: state_next = IDLE;
      endcase
    end else if ((state != IDLE) && (idle_cnt == CNT_LAST)) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    if (in_valid || (state == IDLE) || (idle_cnt == CNT_LAST)) begin
      idle_cnt_next = '0;
    end else begin
      idle_cnt_next = idle_cnt + CNT_W'(1);
    end
  end

  // Left/right modifiers are tracked per key so releasing one side keeps the other held.
  always_comb begin
    mods_next = mods;
    if (fire && fire_mod_en) begin
      if (!fire_ext && (fire_code == CODE_LSHF)) mods_next.lshift = !fire_brk;
      if (!fire_ext && (fire_code == CODE_RSHF)) mods_next.rshift = !fire_brk;
      if (fire_code == CODE_CTRL) begin
        if (fire_ext) mods_next.rctrl = !fire_brk;
        else          mods_next.lctrl = !fire_brk;
      end
      if (fire_code == CODE_ALT) begin
        if (fire_ext) mods_next.ralt = !fire_brk;
        else          mods_next.lalt = !fire_brk;
      end
      if (fire_code == CODE_CAPS) begin
        if (fire_brk) begin
          mods_next.caps_held = 1'b0;
        end else begin
          if (!mods.caps_held) mods_next.caps = !mods.caps;
          mods_next.caps_held = 1'b1;
        end
      end
    end
  end

  assign mods_view = {mods_next.caps,
                      mods_next.lalt   | mods_next.ralt,
                      mods_next.lctrl  | mods_next.rctrl,
                      mods_next.lshift | mods_next.rshift};

  assign load = fire && (!evt_valid || evt_ready);
  assign drop = fire && evt_valid && !evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idle_cnt <= '0;
      mods     <= '0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
      mods     <= mods_next;
    end
  end

`ifdef PS2_DECODER_PAUSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause_cnt <= '0;
    else        pause_cnt <= pause_cnt_next;
  end
`endif

  // Single-entry event slot; a completed event that finds it full is lost and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= 8'h00;
      evt_ext   <= 1'b0;
      evt_break <= 1'b0;
      evt_mods  <= 4'h0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= fire_code;
        evt_ext   <= fire_ext;
        evt_break <= fire_brk;
        evt_mods  <= mods_view;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      overflow <= drop | (overflow & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, hand sequences and a randomized run against a prefix/held-key model.
module tb_ps2_key_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_code;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [3:0] evt_mods;
  logic       overflow;
  logic       ovf_clr;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .evt_mods(evt_mods),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending prefix bytes, set of held keys indexed by {ext, code}.
  bit         m_valid;
  logic [7:0] m_code;
  bit         m_ext, m_brk;
  logic [3:0] m_mods;
  bit         m_ovf;
  logic [7:0] pre[$];
  bit         held[512];
  bit         caps, caps_down;
  int         pause_left;
  longint     cyc = 0;
  longint     last_byte = 0;

  typedef struct {
    logic [7:0] code;
    bit         ev;
    logic [7:0] ecode;
    bit         ext;
    bit         brk;
    logic [3:0] mods;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] c, bit ev, logic [7:0] ec, bit x, bit k, logic [3:0] md);
    vec_t v;
    v.code = c; v.ev = ev; v.ecode = ec; v.ext = x; v.brk = k; v.mods = md;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_ignored(logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  function automatic logic [3:0] m_modbits();
    return {caps, held[9'h011] | held[9'h111], held[9'h014] | held[9'h114],
            held[9'h012] | held[9'h059]};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_code = 8'h00; m_ext = 0; m_brk = 0; m_mods = 4'h0; m_ovf = 0;
    pre.delete();
    foreach (held[i]) held[i] = 0;
    caps = 0; caps_down = 0; pause_left = 0;
  endtask

  task automatic model_edge();
    bit fire, mod_en, has_e0, has_f0, ovf_set;
    logic [7:0] c;
    bit x, k;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire = 0; mod_en = 1; c = in_code; x = 0; k = 0;
    if (in_valid) begin
      if ((pre.size() != 0 || pause_left != 0) && (cyc - last_byte > T)) begin
        pre.delete();
        pause_left = 0;
      end
      last_byte = cyc;
      if (pause_left != 0) begin
        pause_left--;
        if (pause_left == 0) begin
          fire = 1; c = 8'hE1; mod_en = 0;
        end
      end else begin
        has_e0 = 0; has_f0 = 0;
        foreach (pre[i]) begin
          if (pre[i] == 8'hE0) has_e0 = 1;
          if (pre[i] == 8'hF0) has_f0 = 1;
        end
        if (pre.size() == 0 && m_ignored(in_code)) begin
          fire = 0;
`ifdef PS2_DECODER_PAUSE_EN
        end else if (pre.size() == 0 && in_code == 8'hE1) begin
          pause_left = 7;
`endif
        end else if (!has_f0 && in_code == 8'hE0) begin
          if (pre.size() == 0) pre.push_back(8'hE0);
        end else if (!has_f0 && in_code == 8'hF0) begin
          pre.push_back(8'hF0);
        end else begin
          fire = 1; x = has_e0; k = has_f0;
          pre.delete();
        end
      end
    end
    if (fire && mod_en) begin
      held[{x, c}] = !k;
      if (c == 8'h58) begin
        if (!k) begin
          if (!caps_down) caps = !caps;
          caps_down = 1;
        end else begin
          caps_down = 0;
        end
      end
    end
    ovf_set = fire && m_valid && !evt_ready;
    if (fire && (!m_valid || evt_ready)) begin
      m_valid = 1; m_code = c; m_ext = x; m_brk = k; m_mods = m_modbits();
    end else if (evt_ready) begin
      m_valid = 0;
    end
    m_ovf = ovf_set | (m_ovf & !ovf_clr);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("evt_valid", evt_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    if (m_valid) begin
      chk("evt_code", evt_code, m_code);
      chk("evt_ext", evt_ext, m_ext);
      chk("evt_break", evt_break, m_brk);
      chk("evt_mods", evt_mods, m_mods);
    end
    cyc++;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1; in_code = b;
    step();
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 11))
      0: return 8'h12;
      1: return 8'h59;
      2: return 8'h14;
      3: return 8'h11;
      4: return 8'h58;
      5: return 8'h1C;
      6, 7: return 8'hE0;
      8, 9: return 8'hF0;
      10: begin
        case ($urandom_range(0, 3))
          0: return 8'h00;
          1: return 8'hAA;
          2: return 8'hE1;
          default: return 8'hFF;
        endcase
      end
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  int         ev_cnt;
  logic [3:0] last_mods;

  initial begin
    rst_n = 0; in_valid = 0; in_code = 8'h00; evt_ready = 1; ovf_clr = 0;
    model_reset();
    idle(2);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_code", evt_code, 8'h00);
    chk("rst_ext", evt_ext, 1'b0);
    chk("rst_break", evt_break, 1'b0);
    chk("rst_mods", evt_mods, 4'h0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1;
    idle(1);

    tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 1, 4'b0000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h75, 1, 8'h75, 1, 0, 4'b0000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h75, 1, 8'h75, 1, 1, 4'b0000));
    tbl.push_back(mk(8'h12, 1, 8'h12, 0, 0, 4'b0001));
    tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 4'b0001));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h12, 1, 8'h12, 0, 1, 4'b0000));
    tbl.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 0, 4'b1000));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 0, 4'b1000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 1, 4'b1000));
    tbl.push_back(mk(8'h58, 1, 8'h58, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hAA, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hFF, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h12, 1, 8'h12, 1, 0, 4'b0000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h14, 1, 8'h14, 1, 0, 4'b0010));
    tbl.push_back(mk(8'h59, 1, 8'h59, 0, 0, 4'b0011));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h14, 1, 8'h14, 1, 1, 4'b0001));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h59, 1, 8'h59, 0, 1, 4'b0000));
    tbl.push_back(mk(8'h11, 1, 8'h11, 0, 0, 4'b0100));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h11, 1, 8'h11, 0, 1, 4'b0000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'h1C, 1, 8'h1C, 1, 0, 4'b0000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 4'b0000));
    tbl.push_back(mk(8'hE0, 1, 8'hE0, 0, 1, 4'b0000));

    foreach (tbl[i]) begin
      send(tbl[i].code);
      chk("tbl_valid", evt_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_code", evt_code, tbl[i].ecode);
        chk("tbl_ext", evt_ext, tbl[i].ext);
        chk("tbl_break", evt_break, tbl[i].brk);
        chk("tbl_mods", evt_mods, tbl[i].mods);
      end
      idle(1);
    end

    // Back-to-back transfer keeps evt_valid high.
    send(8'h1C);
    send(8'h32);
    chk("b2b_valid", evt_valid, 1'b1);
    chk("b2b_code", evt_code, 8'h32);
    idle(1);
    chk("b2b_drop", evt_valid, 1'b0);

    // Full slot with no consumer: second event dropped, overflow raised.
    evt_ready = 0;
    send(8'h1C);
    idle(2);
    send(8'h32);
    chk("ovf_hold_code", evt_code, 8'h1C);
    chk("ovf_set", overflow, 1'b1);
    ovf_clr = 1;
    idle(1);
    chk("ovf_clr", overflow, 1'b0);
    in_valid = 1; in_code = 8'h33;
    step();
    in_valid = 0; ovf_clr = 0;
    chk("ovf_set_wins", overflow, 1'b1);
    chk("ovf_hold_code2", evt_code, 8'h1C);
    ovf_clr = 1; evt_ready = 1;
    idle(1);
    ovf_clr = 0;
    chk("ovf_drain_valid", evt_valid, 1'b0);
    chk("ovf_cleared", overflow, 1'b0);

    // Timeout boundary: T idle cycles abandons the prefix, T-1 does not.
    send(8'hE0);
    idle(T);
    send(8'h1C);
    chk("tmo_valid", evt_valid, 1'b1);
    chk("tmo_ext", evt_ext, 1'b0);
    idle(1);
    send(8'hE0);
    idle(T - 1);
    send(8'h1C);
    chk("tmo_edge_ext", evt_ext, 1'b1);
    idle(1);

    // Reset mid-sequence abandons the prefix and any pending event.
    evt_ready = 0;
    send(8'h1C);
    send(8'hE0);
    rst_n = 0;
    idle(1);
    chk("rst_mid_valid", evt_valid, 1'b0);
    rst_n = 1; evt_ready = 1;
    send(8'h1C);
    chk("rst_mid_ext", evt_ext, 1'b0);
    idle(1);

    // Pause key sequence.
    ev_cnt = 0; last_mods = 4'h0;
    foreach (tbl[i]) if (i < 0) ev_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      send(seq[i]);
      if (evt_valid) begin
        ev_cnt++;
        last_mods = evt_mods;
      end
      idle(1);
    end
`ifdef PS2_DECODER_PAUSE_EN
    chk("pause_events", ev_cnt, 1);
    chk("pause_code", evt_code, 8'hE1);
`else
    chk("pause_events", ev_cnt, 6);
    chk("pause_last_code", evt_code, 8'h77);
`endif
    chk("pause_ctrl", last_mods[1], 1'b0);

    for (int i = 0; i < 3000; i++) begin
      evt_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 2) != 0) begin
        in_valid = 1; in_code = pick();
      end else begin
        in_valid = 0;
      end
      step();
      in_valid = 0;
      if ($urandom_range(0, 99) == 0) idle($urandom_range(T - 2, T + 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
